// File: rtl/awmc_pkg.sv
// Shared definitions for the AWMC front-panel controller.
//  - AWMC stage codes (idle/paused plus the five wash stages)
//  - panel FSM state encoding
//  - stage -> one-hot LED decode
package awmc_pkg;

  localparam logic [2:0] STG_IDLE  = 3'b111;
  localparam logic [2:0] STG_FILL  = 3'd0;
  localparam logic [2:0] STG_WASH  = 3'd1;
  localparam logic [2:0] STG_RINSE = 3'd2;
  localparam logic [2:0] STG_SPIN  = 3'd3;
  localparam logic [2:0] STG_DRY   = 3'd4;

  // Button slots in the debouncer array
  localparam int NUM_BTN   = 2;
  localparam int BTN_START = 0;
  localparam int BTN_PAUSE = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUNNING,
    ST_PAUSED,
    ST_COMPLETE,
    ST_FAULT
  } panel_state_t;

  // One LED per wash stage; idle and the unused codes 5/6 light nothing.
  function automatic logic [4:0] stage_led_dec(input logic [2:0] s);
    logic [4:0] led;
    led = 5'b0;
    case (s)
      STG_FILL:  led = 5'b00001;
      STG_WASH:  led = 5'b00010;
      STG_RINSE: led = 5'b00100;
      STG_SPIN:  led = 5'b01000;
      STG_DRY:   led = 5'b10000;
      default:   led = 5'b0;
    endcase
    return led;
  endfunction

endpackage

// File: rtl/awmc_debounce.sv
// Button conditioning: 2-flop synchronizer, counting debouncer and a
// registered rising-edge detector.
//  clk, reset : system clock / async active-high reset
//  btn        : raw asynchronous bouncy button (active-high)
//  press      : one-cycle pulse when the debounced level goes 0->1
// The debounced level flips only after DEB_CYCLES consecutive synced
// samples that disagree with it; any agreeing sample restarts the count.
module awmc_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);
  localparam int CW = $clog2(DEB_CYCLES);

  logic          sync1, sync2;
  logic          level, level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      if (sync2 != level) begin
        if (cnt == CW'(DEB_CYCLES - 1)) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
      level_q <= level;
      press   <= level & ~level_q;
    end
  end

endmodule

// File: rtl/awmc_panel_ctrl.sv
// Front-panel / supervisor controller for the AWMC.
//  clk, reset           : system clock / async active-high reset (shared with AWMC)
//  start_btn, pause_btn : raw bouncy buttons
//  door_open            : door switch (synchronized only)
//  stage, done          : AWMC status inputs
//  start                : one-cycle start pulse to AWMC
//  pause                : pause level to AWMC (held while paused/faulted)
//  stage_led            : registered one-hot stage LEDs
//  buzzer               : end-of-cycle buzzer, BUZZ_CYCLES long
//  busy                 : high in RUNNING or PAUSED
//  fault                : sticky stall fault, cleared only by reset
module awmc_panel_ctrl
  import awmc_pkg::*;
#(
  parameter int DEB_CYCLES  = 16,
  parameter int STALL_LIMIT = 64,
  parameter int BUZZ_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic       door_open,
  input  logic [2:0] stage,
  input  logic       done,
  output logic       start,
  output logic       pause,
  output logic [4:0] stage_led,
  output logic       buzzer,
  output logic       busy,
  output logic       fault
);
  localparam int SW = $clog2(STALL_LIMIT);
  localparam int BW = $clog2(BUZZ_CYCLES + 1);

  logic [NUM_BTN-1:0] btn_raw, btn_ev;
  logic               start_ev, pause_ev;

  assign btn_raw[BTN_START] = start_btn;
  assign btn_raw[BTN_PAUSE] = pause_btn;

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
    awmc_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .reset (reset),
      .btn   (btn_raw[b]),
      .press (btn_ev[b])
    );
  end

  assign start_ev = btn_ev[BTN_START];
  assign pause_ev = btn_ev[BTN_PAUSE];

  panel_state_t  state;
  logic          door_m, door_s;
  logic [2:0]    stage_q, last_stage;
  logic [SW-1:0] stall_cnt;
  logic [BW-1:0] buzz_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      door_m     <= 1'b0;
      door_s     <= 1'b0;
      stage_q    <= STG_IDLE;
      last_stage <= STG_IDLE;
      stall_cnt  <= '0;
      buzz_cnt   <= '0;
      start      <= 1'b0;
      pause      <= 1'b0;
      stage_led  <= 5'b0;
      buzzer     <= 1'b0;
      busy       <= 1'b0;
      fault      <= 1'b0;
    end else begin
      door_m    <= door_open;
      door_s    <= door_m;
      stage_q   <= stage;
      stage_led <= stage_led_dec(stage);
      start     <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start_ev && !door_s) begin
            start      <= 1'b1;
            busy       <= 1'b1;
            last_stage <= STG_IDLE;
            stall_cnt  <= '0;
            state      <= ST_RUNNING;
          end
        end

        ST_RUNNING: begin
          if (stage != STG_IDLE) last_stage <= stage;
          // Restart the stall window whenever AWMC moves; saturate otherwise.
          if (stage != stage_q)    stall_cnt <= '0;
          else if (stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;

          // Completion needs the DRY stage to have been seen, so a stale
          // done from an earlier cycle cannot end a fresh run.
          if (done && stage == STG_IDLE && last_stage == STG_DRY) begin
            buzzer   <= 1'b1;
            buzz_cnt <= BW'(BUZZ_CYCLES - 1);
            busy     <= 1'b0;
            state    <= ST_COMPLETE;
          end else if (pause_ev || door_s) begin
            pause <= 1'b1;
            state <= ST_PAUSED;
          end else if (stall_cnt == SW'(STALL_LIMIT - 1)) begin
            pause <= 1'b1;
            fault <= 1'b1;
            busy  <= 1'b0;
            state <= ST_FAULT;
          end
        end

        ST_PAUSED: begin
          if (start_ev && !door_s) begin
            pause     <= 1'b0;
            stall_cnt <= '0;
            state     <= ST_RUNNING;
          end
        end

        ST_COMPLETE: begin
          if (start_ev && !door_s) begin
            buzzer     <= 1'b0;
            start      <= 1'b1;
            busy       <= 1'b1;
            last_stage <= STG_IDLE;
            stall_cnt  <= '0;
            state      <= ST_RUNNING;
          end else if (buzz_cnt == '0) begin
            buzzer <= 1'b0;
          end else begin
            buzz_cnt <= buzz_cnt - 1'b1;
          end
        end

        ST_FAULT: begin
          pause  <= 1'b1;
          fault  <= 1'b1;
          buzzer <= 1'b0;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_awmc_panel_ctrl.sv
// Bench for awmc_panel_ctrl with a small behavioural AWMC model:
// start pulse -> stages 0..4, 4 cycles each, then stage 111 + sticky done.
// pause level parks the model at stage 111 and it resumes when pause drops.
// 'stuck' makes the model jump to stage 1 on start and stay there.
module tb_awmc_panel_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_btn = 1'b0, pause_btn = 1'b0, door_open = 1'b0;
  logic [2:0] stage;
  logic       done;
  logic       start, pause, buzzer, busy, fault;
  logic [4:0] stage_led;
  logic       stuck = 1'b0;

  int total = 0;
  int bad   = 0;

  awmc_panel_ctrl #(.DEB_CYCLES(4), .STALL_LIMIT(16), .BUZZ_CYCLES(32)) dut (
    .clk(clk), .reset(reset), .start_btn(start_btn), .pause_btn(pause_btn),
    .door_open(door_open), .stage(stage), .done(done), .start(start),
    .pause(pause), .stage_led(stage_led), .buzzer(buzzer), .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  // AWMC model
  logic       run, held;
  logic [2:0] cur;
  logic [1:0] dw;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage <= 3'b111; done <= 1'b0; run <= 1'b0; held <= 1'b0; cur <= 3'd0; dw <= 2'd0;
    end else if (stuck) begin
      if (start) stage <= 3'd1;
    end else if (!run) begin
      if (start) begin
        run <= 1'b1; held <= 1'b0; cur <= 3'd0; dw <= 2'd0; stage <= 3'd0;
      end else if (held && !pause) begin
        run <= 1'b1; stage <= cur;
      end
    end else if (pause) begin
      run <= 1'b0; held <= 1'b1; stage <= 3'b111;
    end else if (dw == 2'd3) begin
      dw <= 2'd0;
      if (cur == 3'd4) begin
        run <= 1'b0; held <= 1'b0; stage <= 3'b111; done <= 1'b1;
      end else begin
        cur <= cur + 3'd1; stage <= cur + 3'd1;
      end
    end else begin
      dw <= dw + 2'd1;
    end
  end

  function automatic logic [4:0] exp_led(input logic [2:0] s);
    return (s < 3'd5) ? (5'b1 << s) : 5'b0;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    reset = 1'b1; start_btn = 1'b0; pause_btn = 1'b0; door_open = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(3);
  endtask

  // Follows a run until the buzzer finishes: records the distinct
  // non-idle stages seen, the buzzer length, busy when the buzzer rose
  // and how many cycles the LEDs disagreed with the previous stage.
  task automatic watch_run(output logic [14:0] seq, output int ns, output int bl,
                           output logic bz, output int lb);
    logic [2:0] prev, last;
    seq = '0; ns = 0; bl = 0; bz = 1'b0; lb = 0; prev = stage; last = 3'b111;
    if (stage != 3'b111) begin seq = {12'b0, stage}; ns = 1; last = stage; end
    for (int i = 0; i < 300; i++) begin
      tick(1);
      if (stage_led !== exp_led(prev)) lb++;
      prev = stage;
      if (stage != 3'b111 && stage != last) begin seq = {seq[11:0], stage}; ns++; last = stage; end
      if (buzzer) begin bz = busy; bl = 1; break; end
    end
    if (bl == 1) begin
      for (int i = 0; i < 100; i++) begin
        tick(1);
        if (stage_led !== exp_led(prev)) lb++;
        prev = stage;
        if (buzzer) bl++; else break;
      end
    end
  endtask

  task automatic test_reset();
    tick(3);
    total++; if ({start, pause, stage_led, buzzer, busy, fault} !== 10'b0) begin bad++;
      $display("FAIL reset_outputs got=%b exp=0", {start, pause, stage_led, buzzer, busy, fault}); end
    reset = 1'b0;
    tick(3);
    total++; if ({start, pause, buzzer, busy, fault} !== 5'b0) begin bad++;
      $display("FAIL post_reset_idle got=%b exp=0", {start, pause, buzzer, busy, fault}); end
    total++; if (stage_led !== 5'b0) begin bad++;
      $display("FAIL post_reset_led got=%b exp=0", stage_led); end
  endtask

  task automatic test_start_latency();
    int got = 0, hi = 0, ns, bl, lb;
    logic b = 1'b0, bz;
    logic [14:0] seq;
    do_reset();
    start_btn = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick(1);
      if (i == 10) start_btn = 1'b0;
      if (start) begin hi++; if (got == 0) begin got = i; b = busy; end end
    end
    total++; if (got != 8) begin bad++; $display("FAIL t1_start_latency got=%0d exp=8", got); end
    total++; if (hi != 1) begin bad++; $display("FAIL t1_start_width got=%0d exp=1", hi); end
    total++; if (b !== 1'b1) begin bad++; $display("FAIL t1_busy got=%b exp=1", b); end
    watch_run(seq, ns, bl, bz, lb);
    total++; if (seq !== {3'd0, 3'd1, 3'd2, 3'd3, 3'd4} || ns != 5) begin bad++;
      $display("FAIL t1_stage_seq got=%h/%0d exp=%h/5", seq, ns, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4}); end
    total++; if (bl != 32) begin bad++; $display("FAIL t1_buzz_len got=%0d exp=32", bl); end
    total++; if (bz !== 1'b0) begin bad++; $display("FAIL t1_busy_drop got=%b exp=0", bz); end
    total++; if (lb != 0) begin bad++; $display("FAIL t1_stage_led errors=%0d exp=0", lb); end
  endtask

  task automatic test_bounce();
    int hi = 0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      start_btn = (i % 2 == 0);
      tick(1);
      if (start) hi++;
    end
    start_btn = 1'b1;
    for (int i = 0; i < 10; i++) begin tick(1); if (start) hi++; end
    start_btn = 1'b0;
    for (int i = 0; i < 40; i++) begin tick(1); if (start) hi++; end
    total++; if (hi != 1) begin bad++; $display("FAIL t2_bounce_pulses got=%0d exp=1", hi); end
  endtask

  task automatic test_pause_resume();
    int n = 0, sh = 0, ns, bl, lb;
    logic bz;
    logic [14:0] seq;
    do_reset();
    start_btn = 1'b1;
    for (int i = 0; i < 20; i++) begin tick(1); if (stage == 3'd0) break; end
    total++; if (stage !== 3'd0) begin bad++; $display("FAIL t3_reach_fill got=%0d exp=0", stage); end
    // pressed as FILL begins: debounce delay lands the pause inside RINSE
    start_btn = 1'b0; pause_btn = 1'b1;
    for (int i = 1; i <= 20; i++) begin tick(1); if (pause) begin n = i; break; end end
    total++; if (n != 8) begin bad++; $display("FAIL t3_pause_latency got=%0d exp=8", n); end
    total++; if (stage !== 3'd2) begin bad++; $display("FAIL t3_pause_stage got=%0d exp=2", stage); end
    pause_btn = 1'b0;
    tick(2);
    total++; if ({stage, pause, busy} !== {3'b111, 1'b1, 1'b1}) begin bad++;
      $display("FAIL t3_paused got=%b exp=11111", {stage, pause, busy}); end
    tick(10);
    start_btn = 1'b1; n = 0;
    for (int i = 1; i <= 20; i++) begin tick(1); if (start) sh++; if (!pause) begin n = i; break; end end
    start_btn = 1'b0;
    total++; if (n != 8 || sh != 0) begin bad++;
      $display("FAIL t3_resume got=%0d/%0d exp=8/0", n, sh); end
    watch_run(seq, ns, bl, bz, lb);
    total++; if (seq !== {6'b0, 3'd2, 3'd3, 3'd4} || ns != 3) begin bad++;
      $display("FAIL t3_resume_seq got=%h/%0d exp=%h/3", seq, ns, {6'b0, 3'd2, 3'd3, 3'd4}); end
    total++; if (bl != 32) begin bad++; $display("FAIL t3_buzz_len got=%0d exp=32", bl); end
  endtask

  task automatic test_door();
    int hi = 0, n = 0;
    do_reset();
    door_open = 1'b1;
    tick(3);
    start_btn = 1'b1;
    for (int i = 1; i <= 20; i++) begin tick(1); if (i == 10) start_btn = 1'b0; if (start) hi++; end
    total++; if (hi != 0 || busy !== 1'b0) begin bad++;
      $display("FAIL t4_door_block got=%0d/%b exp=0/0", hi, busy); end
    door_open = 1'b0;
    tick(3);
    start_btn = 1'b1;
    for (int i = 1; i <= 60; i++) begin tick(1); if (i == 10) start_btn = 1'b0; if (stage == 3'd3) break; end
    start_btn = 1'b0;
    total++; if (stage !== 3'd3) begin bad++; $display("FAIL t4_reach_spin got=%0d exp=3", stage); end
    door_open = 1'b1;
    for (int i = 1; i <= 10; i++) begin tick(1); if (pause) begin n = i; break; end end
    total++; if (n != 3 || busy !== 1'b1) begin bad++;
      $display("FAIL t4_door_pause got=%0d/%b exp=3/1", n, busy); end
    door_open = 1'b0;
    tick(10);
    total++; if (pause !== 1'b1 || stage !== 3'b111) begin bad++;
      $display("FAIL t4_no_auto_resume got=%b/%0d exp=1/7", pause, stage); end
  endtask

  task automatic test_stall();
    int n = 0, hi = 0;
    do_reset();
    stuck = 1'b1;
    start_btn = 1'b1;
    for (int i = 1; i <= 20; i++) begin tick(1); if (start) break; end
    start_btn = 1'b0;
    total++; if (start !== 1'b1) begin bad++; $display("FAIL t5_start got=%b exp=1", start); end
    for (int i = 1; i <= 40; i++) begin tick(1); if (fault) begin n = i; break; end end
    total++; if (n != 18) begin bad++; $display("FAIL t5_fault_time got=%0d exp=18", n); end
    total++; if (pause !== 1'b1 || busy !== 1'b0) begin bad++;
      $display("FAIL t5_fault_outs got=%b/%b exp=1/0", pause, busy); end
    start_btn = 1'b1;
    for (int i = 1; i <= 20; i++) begin tick(1); if (i == 10) start_btn = 1'b0; if (start) hi++; end
    total++; if (hi != 0 || fault !== 1'b1 || pause !== 1'b1) begin bad++;
      $display("FAIL t5_fault_sticky got=%0d/%b/%b exp=0/1/1", hi, fault, pause); end
    reset = 1'b1;
    #1;
    total++; if (fault !== 1'b0 || pause !== 1'b0) begin bad++;
      $display("FAIL t5_reset_clear got=%b/%b exp=0/0", fault, pause); end
    stuck = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_reset_midrun();
    int hi = 0, ns, bl, lb;
    logic bz;
    logic [14:0] seq;
    do_reset();
    start_btn = 1'b1;
    for (int i = 1; i <= 60; i++) begin tick(1); if (i == 10) start_btn = 1'b0; if (stage == 3'd3) break; end
    start_btn = 1'b0;
    total++; if (busy !== 1'b1 || stage_led !== 5'b00100) begin bad++;
      $display("FAIL t6_running got=%b/%b exp=1/00100", busy, stage_led); end
    #2 reset = 1'b1;
    #1;
    total++; if ({start, pause, stage_led, buzzer, busy, fault} !== 10'b0) begin bad++;
      $display("FAIL t6_async_reset got=%b exp=0", {start, pause, stage_led, buzzer, busy, fault}); end
    tick(2);
    reset = 1'b0;
    tick(3);
    start_btn = 1'b1;
    for (int i = 1; i <= 12; i++) begin tick(1); if (i == 10) start_btn = 1'b0; if (start) hi++; end
    total++; if (hi != 1) begin bad++; $display("FAIL t6_restart got=%0d exp=1", hi); end
    watch_run(seq, ns, bl, bz, lb);
    total++; if (seq !== {3'd0, 3'd1, 3'd2, 3'd3, 3'd4} || bl != 32) begin bad++;
      $display("FAIL t6_full_run got=%h/%0d exp=%h/32", seq, bl, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4}); end
  endtask

  task automatic test_simultaneous();
    int hi = 0;
    do_reset();
    start_btn = 1'b1; pause_btn = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick(1);
      if (i == 10) begin start_btn = 1'b0; pause_btn = 1'b0; end
      if (start) hi++;
    end
    total++; if (hi != 1 || pause !== 1'b0 || busy !== 1'b1) begin bad++;
      $display("FAIL t7_start_wins got=%0d/%b/%b exp=1/0/1", hi, pause, busy); end
  endtask

  initial begin
    test_reset();
    test_start_latency();
    test_bounce();
    test_pause_resume();
    test_door();
    test_stall();
    test_reset_midrun();
    test_simultaneous();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
